// File: rtl/caliptra_fpga_gpio_log_pkg.sv
// caliptra_fpga_gpio_log_pkg
//   Shared constants for the FPGA GPIO / log-capture block: APB register
//   byte offsets, LOG_STATUS and IRQ_EN bit positions, and the APB
//   transfer phase enumeration used by the slave state machine.
package caliptra_fpga_gpio_log_pkg;

    // Register byte offsets
    localparam logic [31:0] GPIO_IN_OFF    = 32'h00;
    localparam logic [31:0] GPIO_OUT_OFF   = 32'h04;
    localparam logic [31:0] GPIO_RISE_OFF  = 32'h08;
    localparam logic [31:0] LOG_STATUS_OFF = 32'h0C;
    localparam logic [31:0] LOG_DATA_OFF   = 32'h10;
    localparam logic [31:0] IRQ_EN_OFF     = 32'h14;

    // LOG_STATUS fields
    localparam int LOG_STATUS_CNT_W     = 16;
    localparam int LOG_STATUS_EMPTY_BIT = 16;
    localparam int LOG_STATUS_FULL_BIT  = 17;
    localparam int LOG_STATUS_OVF_BIT   = 18;

    // LOG_DATA valid flag
    localparam int LOG_DATA_VALID_BIT = 31;

    // IRQ_EN fields
    localparam int IRQ_EN_W        = 3;
    localparam int IRQ_EN_LOG_BIT  = 0;
    localparam int IRQ_EN_RISE_BIT = 1;
    localparam int IRQ_EN_OVF_BIT  = 2;

    // APB slave phases: IDLE -> WAIT (access cycle 1) -> RESP (pready=1)
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } apb_phase_e;

endpackage

// File: rtl/caliptra_fpga_gpio_log_if.sv
// caliptra_fpga_gpio_log_if
//   APB3 bus bundle between the interconnect (master) and the GPIO/log
//   block (slave).
//   paddr/psel/penable/pwrite/pwdata : master -> slave
//   prdata/pready/pslverr            : slave  -> master
interface caliptra_fpga_gpio_log_if #(
    parameter int APB_ADDR_W = 12
);
    logic [APB_ADDR_W-1:0] paddr;
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [31:0]           pwdata;
    logic [31:0]           prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output paddr, psel, penable, pwrite, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  paddr, psel, penable, pwrite, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/caliptra_fpga_log_fifo.sv
// caliptra_fpga_log_fifo
//   Synchronous first-word-fall-through FIFO for firmware log entries.
//   Ports:
//     clk_i, rst_i   : clock, synchronous active-high reset (pointers only)
//     push_i, data_i : push strobe and entry
//     pop_i          : pop strobe (ignored when empty)
//     count_o        : number of stored entries
//     full_o/empty_o : status
//     head_o         : oldest entry, valid whenever !empty_o
//     drop_o         : push rejected because full with no pop this cycle
module caliptra_fpga_log_fifo #(
    parameter int LOG_DEPTH  = 64,
    parameter int LOG_DATA_W = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  logic [LOG_DATA_W-1:0]          data_i,
    input  logic                           pop_i,
    output logic [$clog2(LOG_DEPTH):0]     count_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [LOG_DATA_W-1:0]          head_o,
    output logic                           drop_o
);
    localparam int AW = $clog2(LOG_DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [LOG_DATA_W-1:0] mem_q [LOG_DEPTH];
    logic                  do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop in the same cycle frees the slot, so a push onto a full FIFO
    // still succeeds when accompanied by a pop.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign drop_o  = push_i && full_o && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (do_push ? 1'b1 : 1'b0);
        rd_ptr_d = rd_ptr_q + (do_pop  ? 1'b1 : 1'b0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/caliptra_fpga_gpio_log.sv
// caliptra_fpga_gpio_log
//   APB-attached GPIO and firmware log capture for the FPGA package top.
//   Ports:
//     core_clk, core_rst : single clock, synchronous active-high reset
//     gpio_in_async      : asynchronous host pins, synchronised here
//     gpio_out           : software-written output register
//     log_wr_en/_data    : one-cycle push of a log entry into the FIFO
//     apb                : APB slave (one wait state on every access)
//     irq                : registered level interrupt
module caliptra_fpga_gpio_log
    import caliptra_fpga_gpio_log_pkg::*;
#(
    parameter int GPIO_IN_W   = 32,
    parameter int GPIO_OUT_W  = 32,
    parameter int SYNC_STAGES = 2,
    parameter int LOG_DEPTH   = 64,
    parameter int LOG_DATA_W  = 8,
    parameter int APB_ADDR_W  = 12
) (
    input  logic                    core_clk,
    input  logic                    core_rst,
    input  logic [GPIO_IN_W-1:0]    gpio_in_async,
    output logic [GPIO_OUT_W-1:0]   gpio_out,
    input  logic                    log_wr_en,
    input  logic [LOG_DATA_W-1:0]   log_wr_data,
    caliptra_fpga_gpio_log_if.slave apb,
    output logic                    irq
);
    localparam int CNT_W = $clog2(LOG_DEPTH) + 1;

    logic [GPIO_IN_W-1:0]  sync_q [SYNC_STAGES];
    logic [GPIO_IN_W-1:0]  gpio_in_q;
    logic [GPIO_IN_W-1:0]  prev_q;
    logic [GPIO_IN_W-1:0]  rise_q, rise_d, rise_clr;
    logic [GPIO_OUT_W-1:0] gpio_out_q, gpio_out_d;
    logic [IRQ_EN_W-1:0]   irq_en_q, irq_en_d;
    logic                  ovf_q, ovf_d, ovf_clr;
    logic                  irq_q, irq_d;

    apb_phase_e            state_q, state_d;
    logic                  access;
    logic [APB_ADDR_W-1:0] addr_q;
    logic                  wr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           prdata_q, prdata_d;
    logic                  pslverr_q, pslverr_d;
    logic                  pop_q, pop_d;

    logic [31:0]           rd_data;
    logic                  rd_err, rd_pop;

    logic                  fifo_pop, fifo_full, fifo_empty, fifo_drop;
    logic [CNT_W-1:0]      fifo_count;
    logic [LOG_DATA_W-1:0] fifo_head;

    caliptra_fpga_log_fifo #(
        .LOG_DEPTH  (LOG_DEPTH),
        .LOG_DATA_W (LOG_DATA_W)
    ) u_log_fifo (
        .clk_i   (core_clk),
        .rst_i   (core_rst),
        .push_i  (log_wr_en),
        .data_i  (log_wr_data),
        .pop_i   (fifo_pop),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (fifo_head),
        .drop_o  (fifo_drop)
    );

    // Input synchroniser; prev_q holds the previous synchronised value
    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_in_async;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            prev_q <= gpio_in_q;
        end
    end

    assign gpio_in_q = sync_q[SYNC_STAGES-1];

    // Read decode, evaluated during access cycle 1 and latched into the
    // response registers. A LOG_DATA read only pops if it saw valid data.
    always_comb begin
        rd_data = '0;
        rd_err  = 1'b0;
        rd_pop  = 1'b0;
        case (32'(apb.paddr))
            GPIO_IN_OFF: begin
                rd_err  = apb.pwrite;
                rd_data = 32'(gpio_in_q);
            end
            GPIO_OUT_OFF:  rd_data = 32'(gpio_out_q);
            GPIO_RISE_OFF: rd_data = 32'(rise_q);
            LOG_STATUS_OFF: begin
                rd_data[LOG_STATUS_CNT_W-1:0]  = LOG_STATUS_CNT_W'(fifo_count);
                rd_data[LOG_STATUS_EMPTY_BIT]  = fifo_empty;
                rd_data[LOG_STATUS_FULL_BIT]   = fifo_full;
                rd_data[LOG_STATUS_OVF_BIT]    = ovf_q;
            end
            LOG_DATA_OFF: begin
                rd_err = apb.pwrite;
                if (!fifo_empty) begin
                    rd_data                     = 32'(fifo_head);
                    rd_data[LOG_DATA_VALID_BIT] = 1'b1;
                    rd_pop                      = !apb.pwrite;
                end
            end
            IRQ_EN_OFF: rd_data = 32'(irq_en_q);
            default:    rd_err  = 1'b1;
        endcase
        if (apb.pwrite) begin
            rd_data = '0;
        end
    end

    // APB phase machine plus register next-state; all side effects fire
    // only in RESP so each transfer acts exactly once.
    always_comb begin
        state_d    = state_q;
        prdata_d   = '0;
        pslverr_d  = 1'b0;
        pop_d      = 1'b0;
        gpio_out_d = gpio_out_q;
        irq_en_d   = irq_en_q;
        rise_clr   = '0;
        ovf_clr    = 1'b0;
        fifo_pop   = 1'b0;
        access     = apb.psel && apb.penable;
        case (state_q)
            IDLE: begin
                if (apb.psel && !apb.penable) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (access) begin
                    state_d   = RESP;
                    prdata_d  = rd_data;
                    pslverr_d = rd_err;
                    pop_d     = rd_pop;
                end else begin
                    state_d = IDLE;
                end
            end
            RESP: begin
                state_d  = IDLE;
                fifo_pop = pop_q;
                if (wr_q) begin
                    case (32'(addr_q))
                        GPIO_OUT_OFF:   gpio_out_d = wdata_q[GPIO_OUT_W-1:0];
                        GPIO_RISE_OFF:  rise_clr   = wdata_q[GPIO_IN_W-1:0];
                        LOG_STATUS_OFF: ovf_clr    = wdata_q[LOG_STATUS_OVF_BIT];
                        IRQ_EN_OFF:     irq_en_d   = wdata_q[IRQ_EN_W-1:0];
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
        // Sticky bits: a new set in the same cycle as a clear wins
        rise_d = (rise_q & ~rise_clr) | (gpio_in_q & ~prev_q);
        ovf_d  = (ovf_q & ~ovf_clr) | fifo_drop;
        irq_d  = |(irq_en_q & {ovf_q, |rise_q, !fifo_empty});
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            state_q    <= IDLE;
            prdata_q   <= '0;
            pslverr_q  <= 1'b0;
            pop_q      <= 1'b0;
            gpio_out_q <= '0;
            irq_en_q   <= '0;
            rise_q     <= '0;
            ovf_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            prdata_q   <= prdata_d;
            pslverr_q  <= pslverr_d;
            pop_q      <= pop_d;
            gpio_out_q <= gpio_out_d;
            irq_en_q   <= irq_en_d;
            rise_q     <= rise_d;
            ovf_q      <= ovf_d;
            irq_q      <= irq_d;
        end
    end

    // Transfer attributes captured at the end of access cycle 1
    always_ff @(posedge core_clk) begin
        if (state_q == WAIT && access) begin
            addr_q  <= apb.paddr;
            wr_q    <= apb.pwrite;
            wdata_q <= apb.pwdata;
        end
    end

    assign apb.prdata  = prdata_q;
    assign apb.pready  = (state_q == RESP);
    assign apb.pslverr = pslverr_q;
    assign gpio_out    = gpio_out_q;
    assign irq         = irq_q;

endmodule
